// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART host-interface scheduler: FSM states,
// guard-counter sizing and the error-counter ceiling.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_TXWAIT,
      ST_READ,
      ST_RXWAIT
   } state_e;

   localparam int TX_GUARD_DEF = 2;
   localparam int RX_GUARD_DEF = 2;

   // Bits needed to count up to the larger of the two guard intervals.
   function automatic int guard_width(input int tx_guard, input int rx_guard);
      int m;
      m = (tx_guard > rx_guard) ? tx_guard : rx_guard;
      return (m + 1 > 2) ? $clog2(m + 1) : 1;
   endfunction

   localparam int GUARD_W = guard_width(TX_GUARD_DEF, RX_GUARD_DEF);
   localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/uart_access_sched_rr_arbiter.sv
// Combinational round-robin search: first active request after ptr_i,
// wrapping modulo NUM_REQ. any_o is low when no request is active.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   int j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = (int'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_access_sched.sv
// Drives the UART core's parallel host port: round-robin TX sharing between
// NUM_REQ producers, RX draining into a one-entry buffer, error counting.
module uart_access_sched
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int TX_GUARD = TX_GUARD_DEF,
   parameter int RX_GUARD = RX_GUARD_DEF
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 rx_valid,
   output logic [7:0]           rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_ovf,
   input  logic                 rx_ready,
   output logic [7:0]           err_count,
   output logic                 uart_csn,
   output logic                 uart_wen,
   output logic                 uart_oen,
   output logic [7:0]           uart_din,
   input  logic [7:0]           uart_dout,
   input  logic                 uart_txrdy,
   input  logic                 uart_rxrdy,
   input  logic                 uart_perr,
   input  logic                 uart_ferr,
   input  logic                 uart_ovf,
   output state_e               dbg_state_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW = guard_width(TX_GUARD, RX_GUARD);

   state_e               state_q, state_d;
   logic [GW-1:0]        guard_q, guard_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [NUM_REQ-1:0]   gvec_q, gvec_d;
   logic [7:0]           din_q, din_d;
   logic                 last_rx_q, last_rx_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic [2:0]           rx_flags_q, rx_flags_d;
   logic [7:0]           err_q, err_d;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [IW-1:0]        arb_idx;
   logic                 arb_any;
   logic                 rx_cand, tx_cand;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // A full buffer still counts as free when the consumer empties it this cycle.
   assign rx_cand = uart_rxrdy & (~rx_valid_q | rx_ready);
   assign tx_cand = arb_any & uart_txrdy;

   always_comb begin
      state_d    = state_q;
      guard_d    = guard_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      gvec_d     = gvec_q;
      din_d      = din_q;
      last_rx_d  = last_rx_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      rx_flags_d = rx_flags_q;
      err_d      = err_q;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_cand && !(tx_cand && last_rx_q)) begin
               state_d   = ST_READ;
               last_rx_d = 1'b1;
            end else if (tx_cand) begin
               state_d   = ST_WRITE;
               gidx_d    = arb_idx;
               gvec_d    = arb_grant;
               din_d     = req_data[int'(arb_idx)*8 +: 8];
               last_rx_d = 1'b0;
            end
         end
         ST_WRITE: begin
            ptr_d   = gidx_q;
            guard_d = '0;
            state_d = ST_TXWAIT;
         end
         ST_TXWAIT: begin
            if (guard_q == GW'(TX_GUARD - 1)) state_d = ST_IDLE;
            else                              guard_d = guard_q + 1'b1;
         end
         ST_READ: begin
            rx_valid_d = 1'b1;
            rx_data_d  = uart_dout;
            rx_flags_d = {uart_perr, uart_ferr, uart_ovf};
            if ((uart_perr | uart_ferr | uart_ovf) && err_q != ERR_MAX)
               err_d = err_q + 8'd1;
            guard_d = '0;
            state_d = ST_RXWAIT;
         end
         ST_RXWAIT: begin
            if (guard_q == GW'(RX_GUARD - 1)) state_d = ST_IDLE;
            else                              guard_d = guard_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         guard_q    <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         gidx_q     <= '0;
         gvec_q     <= '0;
         din_q      <= '0;
         last_rx_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_flags_q <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         guard_q    <= guard_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         gvec_q     <= gvec_d;
         din_q      <= din_d;
         last_rx_q  <= last_rx_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         rx_flags_q <= rx_flags_d;
         err_q      <= err_d;
      end
   end

   // Strobes decode straight from the state register so reset kills them at once.
   assign uart_csn    = !(state_q == ST_WRITE || state_q == ST_READ);
   assign uart_wen    = (state_q != ST_WRITE);
   assign uart_oen    = (state_q != ST_READ);
   assign uart_din    = din_q;
   assign req_ack     = (state_q == ST_WRITE) ? gvec_q : '0;
   assign rx_valid    = rx_valid_q;
   assign rx_data     = rx_data_q;
   assign rx_perr     = rx_flags_q[2];
   assign rx_ferr     = rx_flags_q[1];
   assign rx_ovf      = rx_flags_q[0];
   assign err_count   = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_access_sched.sv
// Self-checking bench for uart_access_sched: directed scenarios plus randomized
// traffic against a round-robin / fairness / saturating-counter reference model.
module tb_uart_access_sched;
   import uart_sched_pkg::*;

   localparam int NREQ = 2;
   localparam int TXG  = 2;
   localparam int RXG  = 2;

   logic              CLK = 1'b0;
   logic              RESET_N;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ack;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_perr, rx_ferr, rx_ovf;
   logic              rx_ready;
   logic [7:0]        err_count;
   logic              uart_csn, uart_wen, uart_oen;
   logic [7:0]        uart_din;
   logic [7:0]        uart_dout;
   logic              uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf;
   state_e            dbg_state;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   int last_grant_m = NREQ - 1;
   bit last_rx_m    = 1'b0;
   int err_m        = 0;

   uart_access_sched #(.NUM_REQ(NREQ), .TX_GUARD(TXG), .RX_GUARD(RXG)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
      .rx_ferr(rx_ferr), .rx_ovf(rx_ovf), .rx_ready(rx_ready),
      .err_count(err_count),
      .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
      .uart_din(uart_din), .uart_dout(uart_dout),
      .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
      .uart_perr(uart_perr), .uart_ferr(uart_ferr), .uart_ovf(uart_ovf),
      .dbg_state_o(dbg_state)
   );

   // clock / reset block
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [NREQ-1:0] onehot(input int r);
      logic [NREQ-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   // Round robin: first valid requester after the last one served.
   function automatic int rr_next(input int last, input logic [NREQ-1:0] mask);
      for (int i = 1; i <= NREQ; i++)
         if (mask[(last + i) % NREQ]) return (last + i) % NREQ;
      return -1;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_strobe(input int limit, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (cyc < limit && uart_csn !== 1'b0);
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      uart_rxrdy = 1'b0;
      uart_txrdy = 1'b1;
      rx_ready   = 1'b0;
      uart_perr  = 1'b0;
      uart_ferr  = 1'b0;
      uart_ovf   = 1'b0;
   endtask

   task automatic settle();
      idle_inputs();
      repeat (6) step();
   endtask

   task automatic test_reset();
      RESET_N   = 1'b0;
      req_data  = '0;
      uart_dout = '0;
      idle_inputs();
      repeat (3) step();
      n_cmp++;
      if ({uart_csn, uart_wen, uart_oen} !== 3'b111) begin
         n_mis++; $display("FAIL reset_strobes: got %b expected 111", {uart_csn, uart_wen, uart_oen});
      end
      n_cmp++;
      if ({uart_din, req_ack} !== '0) begin
         n_mis++; $display("FAIL reset_din_ack: got din=%h ack=%b expected 0", uart_din, req_ack);
      end
      n_cmp++;
      if ({rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf} !== 12'h0) begin
         n_mis++; $display("FAIL reset_rxbuf: got v=%b d=%h f=%b%b%b expected 0", rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf);
      end
      n_cmp++;
      if (err_count !== 8'h00) begin
         n_mis++; $display("FAIL reset_err_count: got %h expected 00", err_count);
      end
      n_cmp++;
      if (dbg_state !== ST_IDLE) begin
         n_mis++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      RESET_N = 1'b1;
      repeat (2) step();
      n_cmp++;
      if ({uart_csn, uart_wen, uart_oen} !== 3'b111) begin
         n_mis++; $display("FAIL idle_no_strobe: got %b expected 111", {uart_csn, uart_wen, uart_oen});
      end
      last_grant_m = NREQ - 1;
      last_rx_m    = 1'b0;
      err_m        = 0;
   endtask

   // One requester pushes two bytes back to back: checks strobe, data, ack and guard spacing.
   task automatic test_single_tx(input logic [7:0] b0, input int r);
      int cyc;
      logic [7:0] b;
      settle();
      b = b0;
      for (int k = 0; k < 2; k++) begin
         req_data[r*8 +: 8] = b;
         req_valid          = onehot(r);
         wait_strobe(10, cyc);
         n_cmp++;
         if (cyc !== ((k == 0) ? 1 : TXG + 2)) begin
            n_mis++; $display("FAIL tx_latency[%0d]: got %0d cycles expected %0d", k, cyc, (k == 0) ? 1 : TXG + 2);
         end
         n_cmp++;
         if ({uart_csn, uart_wen, uart_oen, uart_din, req_ack} !== {3'b001, b, onehot(r)}) begin
            n_mis++; $display("FAIL tx_write[%0d]: got csn/wen/oen=%b din=%h ack=%b expected 001 %h %b",
                              k, {uart_csn, uart_wen, uart_oen}, uart_din, req_ack, b, onehot(r));
         end
         last_grant_m = r;
         last_rx_m    = 1'b0;
         b            = 8'($urandom_range(0, 255));
      end
      req_valid = '0;
      step();
      n_cmp++;
      if ({uart_csn, req_ack} !== {1'b1, {NREQ{1'b0}}}) begin
         n_mis++; $display("FAIL tx_single_cycle: got csn=%b ack=%b expected 1 0", uart_csn, req_ack);
      end
   endtask

   task automatic test_round_robin();
      int cyc, exp_g;
      settle();
      req_data  = {8'h22, 8'h11};
      req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         exp_g = rr_next(last_grant_m, req_valid);
         wait_strobe(10, cyc);
         n_cmp++;
         if (cyc !== ((k == 0) ? 1 : TXG + 2)) begin
            n_mis++; $display("FAIL rr_gap[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? 1 : TXG + 2);
         end
         n_cmp++;
         if ({uart_wen, req_ack, uart_din} !== {1'b0, onehot(exp_g), req_data[exp_g*8 +: 8]}) begin
            n_mis++; $display("FAIL rr_grant[%0d]: got wen=%b ack=%b din=%h expected 0 %b %h",
                              k, uart_wen, req_ack, uart_din, onehot(exp_g), req_data[exp_g*8 +: 8]);
         end
         last_grant_m = exp_g;
         last_rx_m    = 1'b0;
         req_data[exp_g*8 +: 8] = 8'($urandom_range(0, 255));
      end
      req_valid = '0;
   endtask

   // Random masks (requesters may withdraw before ack) and random txrdy stalls.
   task automatic test_random_tx();
      int cyc, exp_g, hold, bad;
      settle();
      for (int k = 0; k < 30; k++) begin
         req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int r = 0; r < NREQ; r++) req_data[r*8 +: 8] = 8'($urandom_range(0, 255));
         exp_g = rr_next(last_grant_m, req_valid);
         if ($urandom_range(0, 2) == 0) begin
            uart_txrdy = 1'b0;
            hold       = $urandom_range(1, 5);
            bad        = 0;
            for (int c = 0; c < hold; c++) begin
               step();
               if (uart_wen !== 1'b1) bad++;
            end
            n_cmp++;
            if (bad !== 0) begin
               n_mis++; $display("FAIL rnd_txrdy_stall[%0d]: got %0d write strobes expected 0", k, bad);
            end
            uart_txrdy = 1'b1;
         end
         wait_strobe(10, cyc);
         n_cmp++;
         if ({uart_wen, req_ack, uart_din} !== {1'b0, onehot(exp_g), req_data[exp_g*8 +: 8]}) begin
            n_mis++; $display("FAIL rnd_grant[%0d]: got wen=%b ack=%b din=%h expected 0 %b %h",
                              k, uart_wen, req_ack, uart_din, onehot(exp_g), req_data[exp_g*8 +: 8]);
         end
         last_grant_m = exp_g;
         last_rx_m    = 1'b0;
      end
      req_valid = '0;
   endtask

   task automatic test_rx();
      int cyc, bad;
      logic [7:0] b2;
      settle();
      uart_dout  = 8'h3C;
      uart_perr  = 1'b1;
      uart_rxrdy = 1'b1;
      wait_strobe(10, cyc);
      n_cmp++;
      if ({cyc, uart_csn, uart_wen, uart_oen} !== {32'd1, 3'b010}) begin
         n_mis++; $display("FAIL rx_read_strobe: got cyc=%0d strobes=%b expected 1 010", cyc, {uart_csn, uart_wen, uart_oen});
      end
      uart_rxrdy = 1'b0;
      step();
      err_m = (err_m < 255) ? err_m + 1 : 255;
      n_cmp++;
      if ({rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf, err_count} !== {1'b1, 8'h3C, 3'b100, 8'(err_m)}) begin
         n_mis++; $display("FAIL rx_capture: got v=%b d=%h f=%b%b%b err=%h expected 1 3c 100 %h",
                           rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf, err_count, 8'(err_m));
      end
      b2         = 8'($urandom_range(0, 255));
      uart_dout  = b2;
      uart_perr  = 1'b0;
      uart_rxrdy = 1'b1;
      bad        = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (uart_oen !== 1'b1) bad++;
      end
      n_cmp++;
      if ({bad, rx_valid, rx_data} !== {32'd0, 1'b1, 8'h3C}) begin
         n_mis++; $display("FAIL rx_full_hold: got reads=%0d v=%b d=%h expected 0 1 3c", bad, rx_valid, rx_data);
      end
      rx_ready = 1'b1;
      step();
      n_cmp++;
      if ({uart_oen, rx_valid} !== 2'b00) begin
         n_mis++; $display("FAIL rx_drain_and_read: got oen=%b v=%b expected 0 0", uart_oen, rx_valid);
      end
      rx_ready   = 1'b0;
      uart_rxrdy = 1'b0;
      step();
      n_cmp++;
      if ({rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf, err_count} !== {1'b1, b2, 3'b000, 8'(err_m)}) begin
         n_mis++; $display("FAIL rx_second: got v=%b d=%h f=%b%b%b err=%h expected 1 %h 000 %h",
                           rx_valid, rx_data, rx_perr, rx_ferr, rx_ovf, err_count, b2, 8'(err_m));
      end
      last_rx_m = 1'b1;
      rx_ready  = 1'b1;
      step();
      n_cmp++;
      if (rx_valid !== 1'b0) begin
         n_mis++; $display("FAIL rx_drain: got v=%b expected 0", rx_valid);
      end
   endtask

   // RX and TX both always pending: services alternate according to last_rx.
   task automatic test_fairness();
      int cyc, exp_g;
      logic [7:0] d;
      test_single_tx(8'($urandom_range(0, 255)), 0);
      settle();
      rx_ready   = 1'b1;
      uart_rxrdy = 1'b1;
      for (int r = 0; r < NREQ; r++) req_data[r*8 +: 8] = 8'($urandom_range(0, 255));
      req_valid  = '1;
      for (int k = 0; k < 8; k++) begin
         d         = 8'($urandom_range(0, 255));
         uart_dout = d;
         wait_strobe(10, cyc);
         if (!last_rx_m) begin
            n_cmp++;
            if ({uart_csn, uart_wen, uart_oen} !== 3'b010) begin
               n_mis++; $display("FAIL fair_expect_rx[%0d]: got %b expected 010", k, {uart_csn, uart_wen, uart_oen});
            end
            last_rx_m = 1'b1;
            step();
            n_cmp++;
            if ({rx_valid, rx_data} !== {1'b1, d}) begin
               n_mis++; $display("FAIL fair_rx_data[%0d]: got v=%b d=%h expected 1 %h", k, rx_valid, rx_data, d);
            end
         end else begin
            exp_g = rr_next(last_grant_m, req_valid);
            n_cmp++;
            if ({uart_csn, uart_wen, uart_oen, req_ack} !== {3'b001, onehot(exp_g)}) begin
               n_mis++; $display("FAIL fair_expect_tx[%0d]: got %b ack=%b expected 001 %b",
                                 k, {uart_csn, uart_wen, uart_oen}, req_ack, onehot(exp_g));
            end
            last_rx_m    = 1'b0;
            last_grant_m = exp_g;
         end
      end
      req_valid = '0;
   endtask

   task automatic test_saturate();
      int cyc;
      logic [2:0] f;
      logic [7:0] d;
      settle();
      rx_ready   = 1'b1;
      uart_rxrdy = 1'b1;
      for (int k = 0; k < 300; k++) begin
         f = 3'($urandom_range(1, 7));
         d = 8'($urandom_range(0, 255));
         {uart_perr, uart_ferr, uart_ovf} = f;
         uart_dout = d;
         wait_strobe(10, cyc);
         n_cmp++;
         if ({uart_csn, uart_wen, uart_oen} !== 3'b010) begin
            n_mis++; $display("FAIL sat_read[%0d]: got %b expected 010", k, {uart_csn, uart_wen, uart_oen});
         end
         step();
         err_m = (err_m < 255) ? err_m + 1 : 255;
         n_cmp++;
         if ({rx_data, rx_perr, rx_ferr, rx_ovf, err_count} !== {d, f, 8'(err_m)}) begin
            n_mis++; $display("FAIL sat_byte[%0d]: got d=%h f=%b%b%b err=%h expected %h %b %h",
                              k, rx_data, rx_perr, rx_ferr, rx_ovf, err_count, d, f, 8'(err_m));
         end
      end
      last_rx_m = 1'b1;
      n_cmp++;
      if (err_count !== 8'hFF) begin
         n_mis++; $display("FAIL sat_final: got %h expected ff", err_count);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      settle();
      req_data[7:0] = 8'($urandom_range(1, 255));
      req_valid     = onehot(0);
      wait_strobe(10, cyc);
      n_cmp++;
      if (uart_wen !== 1'b0) begin
         n_mis++; $display("FAIL areset_setup: got wen=%b expected 0", uart_wen);
      end
      #2 RESET_N = 1'b0;
      #1;
      n_cmp++;
      if ({uart_csn, uart_wen, uart_oen, req_ack, uart_din, err_count} !== {3'b111, {NREQ{1'b0}}, 16'h0000}) begin
         n_mis++; $display("FAIL areset_midcycle: got strobes=%b ack=%b din=%h err=%h expected 111 0 00 00",
                           {uart_csn, uart_wen, uart_oen}, req_ack, uart_din, err_count);
      end
      req_valid = '0;
      step();
      RESET_N = 1'b1;
      step();
      n_cmp++;
      if ({uart_csn, uart_wen, uart_oen, rx_valid} !== 4'b1110) begin
         n_mis++; $display("FAIL areset_after: got %b expected 1110", {uart_csn, uart_wen, uart_oen, rx_valid});
      end
   endtask

   initial begin
      test_reset();
      test_single_tx(8'hA5, 0);
      test_single_tx(8'($urandom_range(0, 255)), 1);
      test_round_robin();
      test_random_tx();
      test_rx();
      test_fairness();
      test_saturate();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
